ice_ram_ctrl: RTL and testbench

- Shared-access controller for one single-port, synchronous-read RAM (1-cycle read latency, write-first output).
- Zero-fills the whole RAM after reset, then round-robin arbitrates up to NUM_REQ requesters with a valid/ready handshake.
- Routes each read result back to the requester that issued it.
- Sits between compute engines (weight/activation buffers) and the RAM instance.

---
 rtl/ice_ram_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 36 +++
 rtl/ice_ram_ctrl.sv | 123 ++++++++++++
 tb/tb_ice_ram_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ice_ram_pkg.sv
// Shared definitions for the RAM access controller and its arbiter.
package ice_ram_pkg;

  // Controller phase: zero-fill the RAM, then serve requesters.
  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Widest data word the shared zero constant can cover.
  localparam int MAX_DATA_W = 256;
  localparam logic [MAX_DATA_W-1:0] ZERO_WORD = '0;

  // Width of a requester index; at least one bit so a single requester
  // still gets a legal vector.
  function automatic int req_idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at ptr, wraps
// modulo N, and the first asserted request wins.
module rr_arbiter
  import ice_ram_pkg::*;
#(
  parameter  int N  = 2,
  localparam int IW = req_idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          any_gnt
);

  int w_cand;

  // Scan requesters in priority order starting from ptr.
  // NOTE: every output gets a default before the loop, so no latch is inferred.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any_gnt = 1'b0;
    w_cand  = 0;
    for (int k = 0; k < N; k++) begin
      w_cand = (int'(ptr) + k) % N;
      if (en && !any_gnt && req[w_cand]) begin
        gnt[w_cand] = 1'b1;
        gnt_idx     = IW'(w_cand);
        any_gnt     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ice_ram_ctrl.sv
// Shared-access controller for one single-port synchronous-read RAM:
// zero-fills the RAM after reset, then round-robin arbitrates requesters
// and routes each read result back to its issuer.
module ice_ram_ctrl
  import ice_ram_pkg::*;
#(
  parameter int ADDR_WIDTH  = 3,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_REQ     = 2,
  parameter int INIT_ENABLE = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic [DATA_WIDTH-1:0]         ram_din,
  output logic [ADDR_WIDTH-1:0]         ram_addr,
  output logic                          ram_write_en,
  input  logic [DATA_WIDTH-1:0]         ram_dout,
  output logic                          init_done
);

  localparam int                     DEPTH       = 1 << ADDR_WIDTH;
  localparam int                     IW          = req_idx_w(NUM_REQ);
  localparam state_e                 RESET_STATE = (INIT_ENABLE != 0) ? ST_INIT : ST_RUN;
  localparam logic [ADDR_WIDTH-1:0]  LAST_ADDR   = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [IW-1:0]          LAST_REQ    = IW'(NUM_REQ - 1);
  localparam logic [DATA_WIDTH-1:0]  ZERO_DATA   = ZERO_WORD[DATA_WIDTH-1:0];

  state_e                  r_state;
  logic [ADDR_WIDTH-1:0]   r_init_cnt;
  logic [IW-1:0]           r_rr_ptr;
  logic                    r_init_done;
  logic [NUM_REQ-1:0]      r_rsp_valid;

  logic                    w_arb_en;
  logic [NUM_REQ-1:0]      w_gnt;
  logic [IW-1:0]           w_gnt_idx;
  logic                    w_any_gnt;
  logic                    w_win_we;
  logic [ADDR_WIDTH-1:0]   w_win_addr;
  logic [DATA_WIDTH-1:0]   w_win_wdata;

  // NOTE: rst_n also gates the combinational RAM/grant outputs, so nothing
  // reaches the RAM or the requesters while reset is held, even though the
  // reset state would otherwise drive fill writes or grants.
  assign w_arb_en = rst_n && (r_state == ST_RUN);

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_arb (
    .req     (req_valid),
    .ptr     (r_rr_ptr),
    .en      (w_arb_en),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx),
    .any_gnt (w_any_gnt)
  );

  // Select the winning requester's command fields.
  always_comb begin
    w_win_we    = req_we[w_gnt_idx];
    w_win_addr  = req_addr[int'(w_gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    w_win_wdata = req_wdata[int'(w_gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
  end

  // Drive the RAM port from the fill counter during INIT, else from the winner.
  always_comb begin
    ram_write_en = 1'b0;
    ram_addr     = '0;
    ram_din      = ZERO_DATA;
    if (rst_n && (r_state == ST_INIT)) begin
      ram_write_en = 1'b1;
      ram_addr     = r_init_cnt;
    end else if (w_any_gnt) begin
      ram_write_en = w_win_we;
      ram_addr     = w_win_addr;
      ram_din      = w_win_wdata;
    end
  end

  assign req_ready = w_gnt;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = ram_dout;
  assign init_done = r_init_done;

  // Phase FSM: walk the fill counter across every address, then enter RUN.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= RESET_STATE;
      r_init_cnt  <= '0;
      r_init_done <= 1'(INIT_ENABLE == 0);
    end else if (r_state == ST_INIT) begin
      r_init_cnt <= r_init_cnt + 1'b1;
      if (r_init_cnt == LAST_ADDR) begin
        r_state     <= ST_RUN;
        r_init_done <= 1'b1;
      end
    end
  end

  // Advance the round-robin pointer past each accepted winner and record
  // which requester owns the read data returning next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr    <= '0;
      r_rsp_valid <= '0;
    end else begin
      r_rsp_valid <= (w_any_gnt && !w_win_we) ? w_gnt : '0;
      if (w_any_gnt) begin
        r_rr_ptr <= (w_gnt_idx == LAST_REQ) ? '0 : w_gnt_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ice_ram_ctrl.sv
// Scoreboard bench for ice_ram_ctrl with a behavioural write-first RAM.
module tb_ice_ram_ctrl;

  localparam int AW = 3;
  localparam int DW = 32;
  localparam int NR = 2;

  typedef struct {
    int          idx;
    logic [31:0] data;
  } exp_t;

  logic              clk;
  logic              rst_n;
  logic [NR-1:0]     req_valid, req_we, req_ready, rsp_valid;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_wdata;
  logic [DW-1:0]     rsp_data, ram_din, ram_dout;
  logic [AW-1:0]     ram_addr;
  logic              ram_write_en, init_done;

  // Second instance without the zero-fill phase.
  logic [NR-1:0]     n_req_valid, n_req_we, n_req_ready, n_rsp_valid;
  logic [NR*AW-1:0]  n_req_addr;
  logic [NR*DW-1:0]  n_req_wdata;
  logic [DW-1:0]     n_rsp_data, n_ram_din, n_ram_dout;
  logic [AW-1:0]     n_ram_addr;
  logic              n_ram_write_en, n_init_done;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_err    = 0;

  ice_ram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(NR), .INIT_ENABLE(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .ram_din(ram_din),
    .ram_addr(ram_addr), .ram_write_en(ram_write_en), .ram_dout(ram_dout),
    .init_done(init_done)
  );

  ice_ram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(NR), .INIT_ENABLE(0)) u_dut_ni (
    .clk(clk), .rst_n(rst_n), .req_valid(n_req_valid), .req_we(n_req_we),
    .req_addr(n_req_addr), .req_wdata(n_req_wdata), .req_ready(n_req_ready),
    .rsp_valid(n_rsp_valid), .rsp_data(n_rsp_data), .ram_din(n_ram_din),
    .ram_addr(n_ram_addr), .ram_write_en(n_ram_write_en), .ram_dout(n_ram_dout),
    .init_done(n_init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port RAM, seeded with non-zero garbage.
  logic [DW-1:0] mem [1<<AW];
  logic          mem_seeded = 1'b0;
  always @(posedge clk) begin
    if (!mem_seeded) begin
      for (int i = 0; i < (1<<AW); i++) mem[i] <= 32'hA5A5_0000 | i;
      mem_seeded <= 1'b1;
      ram_dout   <= 32'h5A5A_5A5A;
    end else if (ram_write_en) begin
      mem[ram_addr] <= ram_din;
      ram_dout      <= ram_din;
    end else begin
      ram_dout <= mem[ram_addr];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every response the DUT presents must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && rsp_valid != '0) begin
      if (sb_q.size() == 0) begin
        check("rsp_unexpected", 64'(rsp_valid), 64'h0);
      end else begin
        e = sb_q.pop_front();
        check("rsp_valid", 64'(rsp_valid), 64'(1) << e.idx);
        check("rsp_data", 64'(rsp_data), 64'(e.data));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[r]            = 1'b1;
    req_we[r]               = we;
    req_addr[r*AW +: AW]    = a;
    req_wdata[r*DW +: DW]   = d;
  endtask

  // Issue one request, wait for its grant, and queue the expected read data.
  task automatic do_req(input string tag, input int r, input bit we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [DW-1:0] exp_data);
    bit granted = 1'b0;
    tick();
    set_req(r, we, a, d);
    for (int c = 0; c < 16 && !granted; c++) begin
      @(negedge clk);
      if (req_ready[r]) granted = 1'b1;
    end
    check({tag, "_grant"}, 64'(granted), 64'h1);
    if (granted) begin
      check({tag, "_ram_cmd"}, {ram_write_en, ram_addr}, {we, a});
      if (we) check({tag, "_ram_din"}, 64'(ram_din), 64'(d));
      @(posedge clk);
      if (!we) sb_q.push_back('{idx: r, data: exp_data});
      #1;
    end
    req_valid[r] = 1'b0;
  endtask

  task automatic drain(input string tag);
    repeat (3) tick();
    check({tag, "_sb_empty"}, 64'(sb_q.size()), 64'h0);
  endtask

  // Called at release of reset: expects DEPTH fill writes, then RUN.
  task automatic init_fill_check(input string tag);
    req_valid = 2'b11;
    req_we    = 2'b00;
    for (int i = 0; i < (1<<AW); i++) begin
      @(negedge clk);
      check($sformatf("%s_fill%0d", tag, i),
            {ram_write_en, ram_addr, ram_din, req_ready, init_done},
            {1'b1, 3'(i), 32'h0, 2'b00, 1'b0});
    end
    req_valid = 2'b00;
    @(negedge clk);
    check({tag, "_run"}, {init_done, ram_write_en, req_ready}, 4'b1000);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    n_req_valid = '0; n_req_we = '0; n_req_addr = '0; n_req_wdata = '0;
    n_ram_dout = 32'hCAFE_F00D;

    // Reset state, with requests pending that must not be granted.
    req_valid = 2'b11;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outs", {ram_write_en, ram_addr, ram_din, req_ready, rsp_valid, init_done}, 64'h0);
    req_valid = 2'b00;
    @(posedge clk);
    #1 rst_n = 1'b1;

    // 1. Fill, then read a zeroed location.
    init_fill_check("t1");
    do_req("t1_rd5", 0, 1'b0, 3'd5, 32'h0, 32'h0);
    drain("t1");

    // 2. Write then read from requester 1.
    do_req("t2_wr3", 1, 1'b1, 3'd3, 32'hDEAD_BEEF, 32'h0);
    do_req("t2_rd3", 1, 1'b0, 3'd3, 32'h0, 32'hDEAD_BEEF);
    drain("t2");

    // 3. Round robin under continuous reads (pointer is back at 0 here).
    do_req("t3_wr1", 0, 1'b1, 3'd1, 32'h1111_0001, 32'h0);
    do_req("t3_wr2", 1, 1'b1, 3'd2, 32'h2222_0002, 32'h0);
    tick();
    set_req(0, 1'b0, 3'd1, 32'h0);
    set_req(1, 1'b0, 3'd2, 32'h0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check($sformatf("t3_rr%0d", k), {req_ready, ram_addr},
            (k % 2 == 0) ? {2'b01, 3'd1} : {2'b10, 3'd2});
      @(posedge clk);
      if (k % 2 == 0) sb_q.push_back('{idx: 0, data: 32'h1111_0001});
      else            sb_q.push_back('{idx: 1, data: 32'h2222_0002});
    end
    #1 req_valid = 2'b00;
    drain("t3");

    // 4. Same-cycle write (r0) and read (r1) of address 4.
    set_req(0, 1'b1, 3'd4, 32'h11);
    set_req(1, 1'b0, 3'd4, 32'h0);
    @(negedge clk);
    check("t4_first", {req_ready, ram_write_en, ram_addr, ram_din}, {2'b01, 1'b1, 3'd4, 32'h11});
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    @(negedge clk);
    check("t4_second", {req_ready, ram_write_en, ram_addr}, {2'b10, 1'b0, 3'd4});
    @(posedge clk);
    sb_q.push_back('{idx: 1, data: 32'h11});
    #1 req_valid[1] = 1'b0;
    drain("t4");

    // 5. Reset with a response in flight, then again mid-fill.
    set_req(0, 1'b0, 3'd4, 32'h0);
    @(negedge clk);
    check("t5_ready", 64'(req_ready), 64'h1);
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    check("t5_rsp_live", 64'(rsp_valid), 64'h1);
    #1 rst_n = 1'b0;
    sb_q.delete();
    #1 check("t5_rsp_clr", {rsp_valid, init_done, ram_write_en}, 4'b0000);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("t5_part%0d", i), {ram_write_en, ram_addr}, {1'b1, 3'(i)});
    end
    rst_n = 1'b0;
    #1 check("t5_mid_rst", {ram_write_en, ram_addr, init_done}, 5'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    init_fill_check("t5");
    do_req("t5_rd3", 1, 1'b0, 3'd3, 32'h0, 32'h0);
    do_req("t5_rd4", 0, 1'b0, 3'd4, 32'h0, 32'h0);
    drain("t5");

    // 6. INIT_ENABLE=0 instance: ready at once, no fill writes.
    n_req_valid = 2'b01;
    n_req_addr[0 +: AW] = 3'd6;
    rst_n = 1'b0;
    sb_q.delete();
    @(negedge clk);
    check("t6_reset", {n_init_done, n_req_ready, n_ram_write_en, n_rsp_valid}, {1'b1, 5'b0});
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("t6_first", {n_init_done, n_req_ready, n_ram_write_en, n_ram_addr, n_ram_din},
          {1'b1, 2'b01, 1'b0, 3'd6, 32'h0});
    @(posedge clk);
    #1 n_req_valid = 2'b00;
    @(negedge clk);
    check("t6_rsp", {n_rsp_valid, n_rsp_data}, {2'b01, 32'hCAFE_F00D});
    @(negedge clk);
    check("t6_idle", {n_rsp_valid, n_ram_write_en}, 3'b000);
    drain("t6");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
